// File: rtl/hqm_core_pkg.sv
// Shared types and constants for the AQED linked-list count RAM audit scan.
package hqm_core_pkg;

    localparam int HQM_AQED_LLCNT_DEPTH  = 2048;
    localparam int HQM_AQED_LLCNT_CNT_W  = 12;
    localparam int HQM_AQED_LLCNT_ADDR_W = 11;
    localparam int HQM_AQED_LLCNT_TOT_W  = 14;
    localparam int HQM_AQED_LLCNT_PRI_W  = 2;

    typedef enum logic [1:0] {
        SCAN_IDLE  = 2'd0,
        SCAN_RUN   = 2'd1,
        SCAN_DRAIN = 2'd2,
        SCAN_DONE  = 2'd3
    } aqed_llcnt_scan_state_t;

    typedef struct packed {
        logic [HQM_AQED_LLCNT_TOT_W-1:0]  nz_total;
        logic                             first_v;
        logic [HQM_AQED_LLCNT_PRI_W-1:0]  first_pri;
        logic [HQM_AQED_LLCNT_ADDR_W-1:0] first_addr;
    } aqed_llcnt_scan_res_t;

endpackage

// File: rtl/hqm_aqed_ll_cnt_nz_enc.sv
// Per-priority non-zero detect for one returned count word: nz vector,
// its popcount and the lowest non-zero priority index.
module hqm_aqed_ll_cnt_nz_enc
    import hqm_core_pkg::*;
#(
    parameter int NUM_PRI = 4,
    parameter int CNT_W   = HQM_AQED_LLCNT_CNT_W,
    parameter int IDX_W   = 2,
    parameter int POP_W   = 3
) (
    input  logic [NUM_PRI*CNT_W-1:0] word,
    output logic [NUM_PRI-1:0]       nz,
    output logic [POP_W-1:0]         nz_cnt,
    output logic [IDX_W-1:0]         low_idx
);

    // Reduce each count field, count hits, and pick the lowest set priority.
    always_comb begin
        nz      = '0;
        nz_cnt  = '0;
        low_idx = '0;
        for (int p = 0; p < NUM_PRI; p++) begin
            nz[p]  = |word[p*CNT_W +: CNT_W];
            nz_cnt = nz_cnt + POP_W'(nz[p]);
        end
        for (int p = NUM_PRI - 1; p >= 0; p--) begin
            if (nz[p]) begin
                low_idx = IDX_W'(p);
            end else begin
                low_idx = low_idx;
            end
        end
    end

endmodule

// File: rtl/hqm_aqed_ll_cnt_scan.sv
// Sweeps all priority count RAMs on idle read cycles and reports the number
// of non-zero entries plus the first non-zero (address, priority) location.
module hqm_aqed_ll_cnt_scan
    import hqm_core_pkg::*;
#(
    parameter int NUM_PRI = 4,
    parameter int DEPTH   = HQM_AQED_LLCNT_DEPTH,
    parameter int ADDR_W  = HQM_AQED_LLCNT_ADDR_W,
    parameter int CNT_W   = HQM_AQED_LLCNT_CNT_W,
    parameter int RD_LAT  = 1,
    parameter int TOT_W   = HQM_AQED_LLCNT_TOT_W
) (
    input  logic                     hqm_gated_clk,
    input  logic                     hqm_gated_rst_n,
    input  logic                     scan_start,
    input  logic                     scan_abort,
    input  logic                     func_rd_v,
    output logic [NUM_PRI-1:0]       rf_ll_cnt_re,
    output logic [ADDR_W-1:0]        rf_ll_cnt_raddr,
    input  logic [NUM_PRI*CNT_W-1:0] rf_ll_cnt_rdata,
    output logic                     scan_busy,
    output logic                     scan_done,
    output logic                     scan_aborted,
    output logic [TOT_W-1:0]         scan_nz_total,
    output logic                     scan_first_v,
    output logic [1:0]               scan_first_pri,
    output logic [ADDR_W-1:0]        scan_first_addr
);

    localparam int POP_W = $clog2(NUM_PRI + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    aqed_llcnt_scan_state_t state_r;
    logic [ADDR_W-1:0]      addr_r;
    logic [RD_LAT-1:0]      vld_pipe_r;
    logic [ADDR_W-1:0]      adr_pipe_r [RD_LAT];
    aqed_llcnt_scan_res_t   res_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   aborted_r;

    logic                   issue_s;
    logic                   abort_s;
    logic                   start_s;
    logic                   eval_s;
    logic [RD_LAT-1:0]      vld_nxt_s;
    logic [NUM_PRI-1:0]     nz_s;
    logic [POP_W-1:0]       nz_cnt_s;
    logic [1:0]             low_idx_s;
    logic [TOT_W-1:0]       nz_cnt_ext_s;
    aqed_llcnt_scan_res_t   res_nxt_s;

    hqm_aqed_ll_cnt_nz_enc #(
        .NUM_PRI (NUM_PRI),
        .CNT_W   (CNT_W),
        .IDX_W   (2),
        .POP_W   (POP_W)
    ) u_nz_enc (
        .word    (rf_ll_cnt_rdata),
        .nz      (nz_s),
        .nz_cnt  (nz_cnt_s),
        .low_idx (low_idx_s)
    );

    // Issue qualification, valid-pipe advance and result accumulation.
    always_comb begin
        issue_s      = (state_r == SCAN_RUN) && !func_rd_v;
        abort_s      = scan_abort && ((state_r == SCAN_RUN) || (state_r == SCAN_DRAIN));
        start_s      = scan_start && (state_r == SCAN_IDLE);
        eval_s       = vld_pipe_r[RD_LAT-1] && !abort_s;
        nz_cnt_ext_s = TOT_W'(nz_cnt_s);
        vld_nxt_s    = '0;
        vld_nxt_s[0] = issue_s;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_nxt_s[i] = vld_pipe_r[i-1];
        end
        res_nxt_s = res_r;
        if (eval_s) begin
            res_nxt_s.nz_total = res_r.nz_total + nz_cnt_ext_s;
            // Address order dominates, so only the first hit word is latched.
            if (!res_r.first_v && (nz_s != '0)) begin
                res_nxt_s.first_v    = 1'b1;
                res_nxt_s.first_pri  = low_idx_s;
                res_nxt_s.first_addr = adr_pipe_r[RD_LAT-1];
            end else begin
                res_nxt_s.first_v = res_r.first_v;
            end
        end else begin
            res_nxt_s = res_r;
        end
    end

    // Scan FSM with address counter, read-valid pipe and registered status.
    always_ff @(posedge hqm_gated_clk or negedge hqm_gated_rst_n) begin
        if (!hqm_gated_rst_n) begin
            state_r    <= SCAN_IDLE;
            addr_r     <= '0;
            vld_pipe_r <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                adr_pipe_r[i] <= '0;
            end
            res_r      <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            aborted_r  <= 1'b0;
        end else begin
            done_r        <= 1'b0;
            aborted_r     <= 1'b0;
            adr_pipe_r[0] <= addr_r;
            for (int i = 1; i < RD_LAT; i++) begin
                adr_pipe_r[i] <= adr_pipe_r[i-1];
            end
            if (abort_s) begin
                state_r    <= SCAN_IDLE;
                vld_pipe_r <= '0;
                busy_r     <= 1'b0;
                aborted_r  <= 1'b1;
            end else begin
                vld_pipe_r <= vld_nxt_s;
                res_r      <= res_nxt_s;
                case (state_r)
                    SCAN_IDLE: begin
                        if (start_s) begin
                            state_r <= SCAN_RUN;
                            addr_r  <= '0;
                            res_r   <= '0;
                            busy_r  <= 1'b1;
                        end else begin
                            state_r <= SCAN_IDLE;
                        end
                    end
                    SCAN_RUN: begin
                        if (issue_s && (addr_r == LAST_ADDR)) begin
                            state_r <= SCAN_DRAIN;
                        end else if (issue_s) begin
                            addr_r <= addr_r + ADDR_W'(1);
                        end else begin
                            state_r <= SCAN_RUN;
                        end
                    end
                    SCAN_DRAIN: begin
                        if (vld_nxt_s == '0) begin
                            state_r <= SCAN_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= SCAN_DRAIN;
                        end
                    end
                    SCAN_DONE: begin
                        state_r <= SCAN_IDLE;
                        busy_r  <= 1'b0;
                    end
                    default: begin
                        state_r <= SCAN_IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rf_ll_cnt_re    = {NUM_PRI{issue_s}};
    assign rf_ll_cnt_raddr = addr_r;
    assign scan_busy       = busy_r;
    assign scan_done       = done_r;
    assign scan_aborted    = aborted_r;
    assign scan_nz_total   = res_r.nz_total;
    assign scan_first_v    = res_r.first_v;
    assign scan_first_pri  = res_r.first_pri;
    assign scan_first_addr = res_r.first_addr;

endmodule

// File: tb/tb_hqm_aqed_ll_cnt_scan.sv
// Self-checking bench: table of full sweeps against a flat-loop reference
// model, plus abort, reset-mid-drain and ignored-start sequences.
module tb_hqm_aqed_ll_cnt_scan;

    localparam int NP    = 4;
    localparam int DEP   = 2048;
    localparam int CW    = 12;
    localparam int RDL   = 1;
    localparam int LAT   = DEP + RDL + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             scan_start = 1'b0;
    logic             scan_abort = 1'b0;
    logic             func_rd_v = 1'b0;
    logic [NP-1:0]    re;
    logic [10:0]      raddr;
    logic [NP*CW-1:0] rdata = '0;
    logic             scan_busy, scan_done, scan_aborted, scan_first_v;
    logic [13:0]      scan_nz_total;
    logic [1:0]       scan_first_pri;
    logic [10:0]      scan_first_addr;

    logic [CW-1:0]    mem [NP][DEP];
    int               n_cmp = 0;
    int               n_err = 0;
    int               mon_exp_addr = 0;
    int               mon_re_cnt = 0;
    int               mon_bad = 0;

    hqm_aqed_ll_cnt_scan #(.RD_LAT(RDL)) dut (
        .hqm_gated_clk   (clk),
        .hqm_gated_rst_n (rst_n),
        .scan_start      (scan_start),
        .scan_abort      (scan_abort),
        .func_rd_v       (func_rd_v),
        .rf_ll_cnt_re    (re),
        .rf_ll_cnt_raddr (raddr),
        .rf_ll_cnt_rdata (rdata),
        .scan_busy       (scan_busy),
        .scan_done       (scan_done),
        .scan_aborted    (scan_aborted),
        .scan_nz_total   (scan_nz_total),
        .scan_first_v    (scan_first_v),
        .scan_first_pri  (scan_first_pri),
        .scan_first_addr (scan_first_addr)
    );

    always #5 clk = ~clk;

    // RAM model: one-cycle read latency, garbage on the bus when not read.
    always @(posedge clk) begin
        if (re[0]) begin
            for (int p = 0; p < NP; p++) rdata[p*CW +: CW] <= mem[p][raddr];
        end else begin
            rdata <= {$urandom, $urandom};
        end
    end

    // Read-port monitor: ascending unique addresses, never while the pipe owns the port.
    always @(negedge clk) begin
        if (rst_n && scan_start && !scan_busy) begin
            mon_exp_addr <= 0;
            mon_re_cnt   <= 0;
            mon_bad      <= 0;
        end else if (re != '0) begin
            if (re != 4'hF || func_rd_v || int'(raddr) != mon_exp_addr) mon_bad <= mon_bad + 1;
            mon_exp_addr <= mon_exp_addr + 1;
            mon_re_cnt   <= mon_re_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fill(input int kind);
        for (int p = 0; p < NP; p++)
            for (int a = 0; a < DEP; a++) begin
                case (kind)
                    2: mem[p][a] = 12'($urandom_range(1, 4095));
                    3: mem[p][a] = ($urandom_range(0, 499) == 0) ? 12'($urandom_range(1, 4095)) : 12'h000;
                    default: mem[p][a] = 12'h000;
                endcase
            end
        if (kind == 1) begin
            mem[2][11'h005] = 12'h003;
            mem[0][11'h7FF] = 12'h001;
            mem[1][11'h005] = 12'h800;
        end
    endtask

    // Reference: scan addresses 0..last in order, priorities low to high within each.
    task automatic model(input int last, output int tot, output bit fv, output int fp, output int fa);
        tot = 0; fv = 1'b0; fp = 0; fa = 0;
        for (int a = 0; a <= last; a++)
            for (int p = 0; p < NP; p++)
                if (mem[p][a] != 12'h000) begin
                    tot++;
                    if (!fv) begin fv = 1'b1; fp = p; fa = a; end
                end
    endtask

    // Start a scan and wait (bounded) for its done pulse; returns edges from start.
    task automatic run_scan(input int stall, input bit extra, output int lat, output bit got);
        lat = 0; got = 1'b0;
        scan_start = 1'b1;
        for (int c = 1; c <= 20000; c++) begin
            @(posedge clk); #1;
            scan_start = extra && (c == 100);
            func_rd_v  = ($urandom_range(0, 99) < stall);
            if (c == 1) begin
                check("start_clear_total", 32'(scan_nz_total), 32'd0);
                check("start_clear_fv", 32'(scan_first_v), 32'd0);
                check("start_busy", 32'(scan_busy), 32'd1);
            end
            if (scan_done) begin lat = c; got = 1'b1; break; end
        end
        func_rd_v  = 1'b0;
        scan_start = 1'b0;
    endtask

    typedef struct {
        int fill; int stall; bit extra; bit chk_lat; bit use_model;
        int tot; bit fv; int fp; int fa;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat, etot, efp, efa, dn;
        bit got, efv, found;

        vecs[0] = '{0, 0,  1'b0, 1'b1, 1'b0, 0,    1'b0, 0, 0};
        vecs[1] = '{1, 0,  1'b0, 1'b1, 1'b0, 3,    1'b1, 1, 5};
        vecs[2] = '{1, 50, 1'b0, 1'b0, 1'b0, 3,    1'b1, 1, 5};
        vecs[3] = '{2, 0,  1'b1, 1'b1, 1'b0, 8192, 1'b1, 0, 0};
        vecs[4] = '{2, 30, 1'b0, 1'b0, 1'b0, 8192, 1'b1, 0, 0};
        vecs[5] = '{3, 50, 1'b1, 1'b0, 1'b1, 0,    1'b0, 0, 0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {re, raddr, scan_busy, scan_done, scan_aborted, scan_nz_total,
                                 scan_first_v, scan_first_pri}, 32'd0);
        check("reset_first_addr", 32'(scan_first_addr), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            fill(vecs[i].fill);
            if (vecs[i].use_model) begin
                model(DEP - 1, etot, efv, efp, efa);
            end else begin
                etot = vecs[i].tot; efv = vecs[i].fv; efp = vecs[i].fp; efa = vecs[i].fa;
            end
            run_scan(vecs[i].stall, vecs[i].extra, lat, got);
            check($sformatf("v%0d_done_seen", i), 32'(got), 32'd1);
            if (vecs[i].chk_lat) check($sformatf("v%0d_latency", i), 32'(lat), 32'(LAT));
            check($sformatf("v%0d_nz_total", i), 32'(scan_nz_total), 32'(etot));
            check($sformatf("v%0d_first_v", i), 32'(scan_first_v), 32'(efv));
            if (efv) begin
                check($sformatf("v%0d_first_pri", i), 32'(scan_first_pri), 32'(efp));
                check($sformatf("v%0d_first_addr", i), 32'(scan_first_addr), 32'(efa));
            end
            check($sformatf("v%0d_re_count", i), 32'(mon_re_cnt), 32'(DEP));
            check($sformatf("v%0d_port_order", i), 32'(mon_bad), 32'd0);
            @(posedge clk); #1;
            check($sformatf("v%0d_done_one_cycle", i), {30'd0, scan_done, scan_busy}, 32'd0);
            check($sformatf("v%0d_idle_hold", i), 32'(scan_nz_total), 32'(etot));
        end

        // Abort at address 0x100 with partial hits already accumulated.
        fill(1);
        scan_start = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            scan_start = 1'b0;
            if (raddr == 11'h100) begin found = 1'b1; break; end
        end
        check("abort_reach_addr", 32'(found), 32'd1);
        scan_abort = 1'b1;
        @(posedge clk); #1;
        scan_abort = 1'b0;
        check("abort_pulse", {30'd0, scan_aborted, scan_busy}, 32'd2);
        model(11'h0FE, etot, efv, efp, efa);
        check("abort_partial_total", 32'(scan_nz_total), 32'(etot));
        check("abort_partial_first", {scan_first_v, scan_first_pri, scan_first_addr},
              32'({efv, 2'(efp), 11'(efa)}));
        dn = 0;
        @(posedge clk); #1;
        check("abort_one_cycle", 32'(scan_aborted), 32'd0);
        repeat (20) begin @(posedge clk); #1; dn += int'(scan_done); end
        check("abort_no_done", 32'(dn), 32'd0);
        run_scan(0, 1'b0, lat, got);
        check("rescan_latency", 32'(lat), 32'(LAT));
        check("rescan_total", 32'(scan_nz_total), 32'd3);
        check("rescan_first", {scan_first_v, scan_first_pri, scan_first_addr}, 32'({1'b1, 2'd1, 11'h005}));
        check("rescan_order", 32'(mon_bad), 32'd0);

        // Reset in the DRAIN cycle discards everything, no pulses afterwards.
        @(posedge clk); #1;
        scan_start = 1'b1;
        for (int c = 1; c <= LAT - 1; c++) begin
            @(posedge clk); #1;
            scan_start = 1'b0;
        end
        check("drain_busy_no_done", {30'd0, scan_busy, scan_done}, 32'd2);
        rst_n = 1'b0;
        #1;
        check("rst_mid_drain", {re, raddr, scan_busy, scan_done, scan_aborted, scan_nz_total,
                                 scan_first_v, scan_first_pri}, 32'd0);
        check("rst_mid_drain_addr", 32'(scan_first_addr), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dn = 0;
        repeat (10) begin @(posedge clk); #1; dn += int'(scan_done) + int'(scan_aborted) + int'(scan_busy); end
        check("post_rst_quiet", 32'(dn), 32'd0);

        fill(3);
        model(DEP - 1, etot, efv, efp, efa);
        run_scan(40, 1'b0, lat, got);
        check("final_done", 32'(got), 32'd1);
        check("final_total", 32'(scan_nz_total), 32'(etot));
        check("final_first", {scan_first_v, scan_first_pri, (efv ? scan_first_addr : 11'h000)},
              32'({efv, (efv ? 2'(efp) : scan_first_pri), 11'(efa)}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hqm_aqed_ll_cnt_scan.md
Name: hqm_aqed_ll_cnt_scan

Overview:
- Read-side audit engine for the AQED per-priority linked-list count RAMs (rf_aqed_ll_cnt_pri0..3, 2048 x 12b count field).
- On request, sweeps every address of all priority RAMs through their read ports and reports how many entries are non-zero, plus the first non-zero location.
- Steals only idle read cycles from the AQED pipe.
- Used by idle/drain checks and CFG-triggered debug status; complements the write-side shadow tracking.

Parameters:
- NUM_PRI, 4, number of priority count RAMs scanned in parallel.
- DEPTH, 2048, entries per RAM.
- ADDR_W, 11, log2(DEPTH).
- CNT_W, 12, count field width per entry.
- RD_LAT, 1, RAM read latency in cycles; legal values 1 or 2.
- TOT_W, 14, width of total non-zero counter; must hold NUM_PRI*DEPTH.

Ports:
- hqm_gated_clk, input, 1, clock.
- hqm_gated_rst_n, input, 1, asynchronous active-low reset.
- scan_start, input, 1, single-cycle start request.
- scan_abort, input, 1, terminate an active scan.
- func_rd_v, input, 1, AQED pipe owns the read ports this cycle.
- rf_ll_cnt_re, output, NUM_PRI, read enable per priority RAM; all bits identical.
- rf_ll_cnt_raddr, output, ADDR_W, shared read address.
- rf_ll_cnt_rdata, input, NUM_PRI*CNT_W, read data; priority p occupies bits [p*CNT_W +: CNT_W].
- scan_busy, output, 1, scan in progress.
- scan_done, output, 1, one-cycle pulse when a full sweep completes.
- scan_aborted, output, 1, one-cycle pulse on abort.
- scan_nz_total, output, TOT_W, number of non-zero entries found.
- scan_first_v, output, 1, at least one non-zero entry found.
- scan_first_pri, output, 2, priority of the first non-zero entry.
- scan_first_addr, output, ADDR_W, address of the first non-zero entry.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; address counter 0; read-valid pipe cleared. Reset mid-scan discards all progress. No done or aborted pulse is generated by reset.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on scan_start. Results are cleared the same cycle; address counter is set to 0. Results hold their last value while in IDLE.
- RUN:
  - Issue cycle: a cycle in which func_rd_v=0. The block drives re=all-ones and raddr=addr, then increments addr.
  - If func_rd_v=1: re=0; addr holds.
  - After issuing addr=DEPTH-1, go to DRAIN. addr never wraps within a scan.
- Read-valid pipe: each issue enters a valid pipe of depth RD_LAT. Returning data is evaluated when the pipe output is valid, independent of func_rd_v. A stall never drops in-flight data.
- DRAIN -> DONE when the pipe holds no valid entries.
- DONE: scan_done=1 for exactly one cycle, then IDLE.
- scan_busy=1 in RUN, DRAIN and DONE.
- Evaluation of a returned word:
  - nz[p] = OR-reduce of the priority p count field.
  - scan_nz_total += popcount(nz).
  - No saturation is required: TOT_W covers the maximum count of 8192.
  - If scan_first_v=0 and nz!=0: latch the lowest p with nz[p]=1 together with its address, and set scan_first_v. Address order is primary, priority order secondary.
  - The returned address is carried down the valid pipe alongside the valid bit.
- scan_start while busy is ignored.
- scan_abort in RUN/DRAIN: next state IDLE; scan_aborted pulses one cycle; the valid pipe is flushed; partial results remain visible. Abort in IDLE or DONE is ignored. Abort wins over start in the same cycle.
- Latency: an unstalled scan takes DEPTH + RD_LAT + 1 cycles from the start cycle to the done pulse.

Decomposition:
- hqm_core_pkg holds:
  - the FSM state enum aqed_llcnt_scan_state_t;
  - the result struct aqed_llcnt_scan_res_t {nz_total, first_v, first_pri, first_addr};
  - constants HQM_AQED_LLCNT_DEPTH and HQM_AQED_LLCNT_CNT_W.
- One combinational sub-module, hqm_aqed_ll_cnt_nz_enc: takes the NUM_PRI*CNT_W word and produces the nz vector, its popcount, and the lowest-set index.

Test Plan:
- All RAMs zero, start, no stalls, RD_LAT=1 -> done pulse 2050 cycles after start; nz_total=0; first_v=0; re asserted on exactly 2048 cycles.
- pri2[0x005]=3, pri0[0x7FF]=1, pri1[0x005]=12'h800 -> nz_total=3; first_v=1; first_pri=1; first_addr=0x005.
- func_rd_v toggled 50% random during the scan with the same data as above -> identical results. re is never asserted when func_rd_v=1. Each address is issued exactly once, in ascending order.
- Every entry of all 4 RAMs non-zero -> nz_total=8192 (14'h2000); first_pri=0; first_addr=0.
- scan_abort at addr=0x100 -> one scan_aborted pulse, no scan_done, busy=0 the next cycle. A following start rescans from 0 with cleared results.
- hqm_gated_rst_n asserted mid-DRAIN -> all outputs 0 immediately. scan_start during a scan has no effect: completion cycle and results are unchanged.
